// File: rtl/vga_timing_pkg.sv
// Shared timing sets and helpers for the raster timing generator.
// Provides standard 640x480@60 and 800x600@60 parameters plus counter sizing helpers.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned pulse;
        int unsigned back;
    } axis_timing_t;

    localparam axis_timing_t VGA640_H = '{active: 640, front: 16, pulse: 96, back: 48};
    localparam axis_timing_t VGA640_V = '{active: 480, front: 10, pulse: 2,  back: 33};
    localparam int unsigned  VGA640_H_POL = 0;
    localparam int unsigned  VGA640_V_POL = 0;

    localparam axis_timing_t VGA800_H = '{active: 800, front: 40, pulse: 128, back: 88};
    localparam axis_timing_t VGA800_V = '{active: 600, front: 1,  pulse: 4,   back: 23};
    localparam int unsigned  VGA800_H_POL = 1;
    localparam int unsigned  VGA800_V_POL = 1;

    function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned axis_total(input axis_timing_t t);
        return total(t.active, t.front, t.pulse, t.back);
    endfunction

    // A one-state axis still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle from the generator (master) to the VGA pins and framebuffer fetch (slave).
// The lookahead fetch signals exist only when VGA_TIMING_FETCH_EN is defined.
interface vga_timing_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);

    logic          vga_h_sync;
    logic          vga_v_sync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

`ifdef VGA_TIMING_FETCH_EN
    logic [XW-1:0] fetch_x;
    logic [YW-1:0] fetch_y;
    logic          fetch_de;

    modport master (
        output vga_h_sync, vga_v_sync, de, x, y, line_start, frame_start,
        output fetch_x, fetch_y, fetch_de
    );

    modport slave (
        input vga_h_sync, vga_v_sync, de, x, y, line_start, frame_start,
        input fetch_x, fetch_y, fetch_de
    );
`else
    modport master (
        output vga_h_sync, vga_v_sync, de, x, y, line_start, frame_start
    );

    modport slave (
        input vga_h_sync, vga_v_sync, de, x, y, line_start, frame_start
    );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; wrap flags the advance out of TOTAL-1.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL     = 800,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    output logic [cnt_width(TOTAL)-1:0]  cnt,
    output logic                         wrap
);

    localparam int unsigned  W    = cnt_width(TOTAL);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] INIT = W'(RESET_VAL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = inc && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: syncs, display enable, coordinates and strobes.
// Define VGA_TIMING_FETCH_EN to add a lookahead fetch port leading x/y/de by FETCH_LEAD pixels.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA640_H.active,
    parameter int unsigned H_FP       = VGA640_H.front,
    parameter int unsigned H_SYNC     = VGA640_H.pulse,
    parameter int unsigned H_BP       = VGA640_H.back,
    parameter int unsigned V_ACTIVE   = VGA640_V.active,
    parameter int unsigned V_FP       = VGA640_V.front,
    parameter int unsigned V_SYNC     = VGA640_V.pulse,
    parameter int unsigned V_BP       = VGA640_V.back,
    parameter int unsigned H_SYNC_POL = VGA640_H_POL,
    parameter int unsigned V_SYNC_POL = VGA640_V_POL,
    parameter int unsigned FETCH_LEAD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_ce,
    vga_timing_if.master vga
);

    localparam int unsigned H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned XW       = cnt_width(H_TOTAL);
    localparam int unsigned YW       = cnt_width(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam logic        HS_ON    = (H_SYNC_POL != 0);
    localparam logic        VS_ON    = (V_SYNC_POL != 0);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap;
    logic          unused_v_wrap;

    vga_axis_counter #(
        .TOTAL     (H_TOTAL),
        .RESET_VAL (0)
    ) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (pix_ce),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL     (V_TOTAL),
        .RESET_VAL (0)
    ) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (h_wrap),
        .cnt  (v_cnt),
        .wrap (unused_v_wrap)
    );

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          de_q, de_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Outputs are decoded from the pre-edge counters, so everything lands one clk later together.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            x_d           = h_cnt;
            y_d           = v_cnt;
            de_d          = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
            h_sync_d      = in_window(32'(h_cnt), HS_START, H_SYNC) ? HS_ON : ~HS_ON;
            v_sync_d      = in_window(32'(v_cnt), VS_START, V_SYNC) ? VS_ON : ~VS_ON;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            h_sync_q      <= ~HS_ON;
            v_sync_q      <= ~VS_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.de          = de_q;
    assign vga.vga_h_sync  = h_sync_q;
    assign vga.vga_v_sync  = v_sync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FETCH_EN
    // Fetch counters start FETCH_LEAD pixels ahead of (0,0) and then advance in lockstep.
    localparam int unsigned FH_INIT = FETCH_LEAD % H_TOTAL;
    localparam int unsigned FV_INIT = (FETCH_LEAD / H_TOTAL) % V_TOTAL;

    logic [XW-1:0] fh_cnt;
    logic [YW-1:0] fv_cnt;
    logic          fh_wrap;
    logic          unused_fv_wrap;

    vga_axis_counter #(
        .TOTAL     (H_TOTAL),
        .RESET_VAL (FH_INIT)
    ) u_fetch_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (pix_ce),
        .cnt  (fh_cnt),
        .wrap (fh_wrap)
    );

    vga_axis_counter #(
        .TOTAL     (V_TOTAL),
        .RESET_VAL (FV_INIT)
    ) u_fetch_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (fh_wrap),
        .cnt  (fv_cnt),
        .wrap (unused_fv_wrap)
    );

    logic [XW-1:0] fetch_x_q, fetch_x_d;
    logic [YW-1:0] fetch_y_q, fetch_y_d;
    logic          fetch_de_q, fetch_de_d;

    always_comb begin
        fetch_x_d  = fetch_x_q;
        fetch_y_d  = fetch_y_q;
        fetch_de_d = fetch_de_q;
        if (pix_ce) begin
            fetch_x_d  = fh_cnt;
            fetch_y_d  = fv_cnt;
            fetch_de_d = (32'(fh_cnt) < H_ACTIVE) && (32'(fv_cnt) < V_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_x_q  <= '0;
            fetch_y_q  <= '0;
            fetch_de_q <= 1'b0;
        end else begin
            fetch_x_q  <= fetch_x_d;
            fetch_y_q  <= fetch_y_d;
            fetch_de_q <= fetch_de_d;
        end
    end

    assign vga.fetch_x  = fetch_x_q;
    assign vga.fetch_y  = fetch_y_q;
    assign vga.fetch_de = fetch_de_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced mode, its reversed-polarity twin and the default 640x480 mode.
// Build with VGA_TIMING_FETCH_EN to cover the lookahead fetch port as well.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int unsigned S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
    localparam int unsigned S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
    localparam int unsigned S_HT = 25, S_VT = 12;
    localparam int unsigned LEAD = 2;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [9:0] fx;
        logic [9:0] fy;
        logic       fde;
    } obs_t;

    typedef struct {
        int unsigned h;
        int unsigned v;
        obs_t        o;
    } mst_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic pix_ce = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    obs_t q_s[$];
    obs_t q_d[$];
    logic fde_hist[$];
    mst_t st_s;
    mst_t st_d;

    always #5 clk = ~clk;

    vga_timing_if #(.XW(5),  .YW(4))  s_if ();
    vga_timing_if #(.XW(5),  .YW(4))  p_if ();
    vga_timing_if #(.XW(10), .YW(10)) d_if ();

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .FETCH_LEAD(LEAD)
    ) dut_s (.clk(clk), .rst(rst), .pix_ce(pix_ce), .vga(s_if));

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .FETCH_LEAD(LEAD)
    ) dut_p (.clk(clk), .rst(rst), .pix_ce(pix_ce), .vga(p_if));

    vga_timing_gen dut_d (.clk(clk), .rst(rst), .pix_ce(pix_ce), .vga(d_if));

    // Behavioural reference for an active-low-sync mode; returns the state after one clk edge.
    function automatic mst_t model_step(input mst_t st, input logic r, input logic ce,
                                        input int unsigned ha, input int unsigned hf,
                                        input int unsigned hs, input int unsigned hb,
                                        input int unsigned va, input int unsigned vf,
                                        input int unsigned vs, input int unsigned vb);
        mst_t        n;
        int unsigned ht;
        int unsigned vt;
        n  = st;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        n.o.ls = 1'b0;
        n.o.fs = 1'b0;
        if (r) begin
            n.h    = 0;
            n.v    = 0;
            n.o    = '0;
            n.o.hs = 1'b1;
            n.o.vs = 1'b1;
        end else if (ce) begin
            n.o.x  = 10'(st.h);
            n.o.y  = 10'(st.v);
            n.o.de = (st.h < ha) && (st.v < va);
            n.o.hs = !((st.h >= ha + hf) && (st.h < ha + hf + hs));
            n.o.vs = !((st.v >= va + vf) && (st.v < va + vf + vs));
            n.o.ls = (st.h == 0);
            n.o.fs = (st.h == 0) && (st.v == 0);
`ifdef VGA_TIMING_FETCH_EN
            begin : fetch_model
                int unsigned fh;
                int unsigned fv;
                fh = st.h + LEAD;
                fv = st.v;
                if (fh >= ht) begin
                    fh = fh - ht;
                    fv = (fv + 1 == vt) ? 0 : fv + 1;
                end
                n.o.fx  = 10'(fh);
                n.o.fy  = 10'(fv);
                n.o.fde = (fh < ha) && (fv < va);
            end
`endif
            if (st.h + 1 == ht) begin
                n.h = 0;
                n.v = (st.v + 1 == vt) ? 0 : st.v + 1;
            end else begin
                n.h = st.h + 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t grab_s();
        obs_t g = '0;
        g.hs = s_if.vga_h_sync;
        g.vs = s_if.vga_v_sync;
        g.de = s_if.de;
        g.x  = 10'(s_if.x);
        g.y  = 10'(s_if.y);
        g.ls = s_if.line_start;
        g.fs = s_if.frame_start;
`ifdef VGA_TIMING_FETCH_EN
        g.fx  = 10'(s_if.fetch_x);
        g.fy  = 10'(s_if.fetch_y);
        g.fde = s_if.fetch_de;
`endif
        return g;
    endfunction

    function automatic obs_t grab_p();
        obs_t g = '0;
        g.hs = p_if.vga_h_sync;
        g.vs = p_if.vga_v_sync;
        g.de = p_if.de;
        g.x  = 10'(p_if.x);
        g.y  = 10'(p_if.y);
        g.ls = p_if.line_start;
        g.fs = p_if.frame_start;
`ifdef VGA_TIMING_FETCH_EN
        g.fx  = 10'(p_if.fetch_x);
        g.fy  = 10'(p_if.fetch_y);
        g.fde = p_if.fetch_de;
`endif
        return g;
    endfunction

    function automatic obs_t grab_d();
        obs_t g = '0;
        g.hs = d_if.vga_h_sync;
        g.vs = d_if.vga_v_sync;
        g.de = d_if.de;
        g.x  = d_if.x;
        g.y  = d_if.y;
        g.ls = d_if.line_start;
        g.fs = d_if.frame_start;
`ifdef VGA_TIMING_FETCH_EN
        g.fx  = d_if.fetch_x;
        g.fy  = d_if.fetch_y;
        g.fde = d_if.fetch_de;
`endif
        return g;
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Drive one clk of stimulus, queue the model's prediction, then score the DUT outputs.
    task automatic step(input logic r, input logic ce);
        obs_t es;
        obs_t ep;
        obs_t ed;
        rst    = r;
        pix_ce = ce;
        st_s = model_step(st_s, r, ce, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
        q_s.push_back(st_s.o);
        st_d = model_step(st_d, r, ce, VGA640_H.active, VGA640_H.front, VGA640_H.pulse,
                          VGA640_H.back, VGA640_V.active, VGA640_V.front, VGA640_V.pulse,
                          VGA640_V.back);
        q_d.push_back(st_d.o);
        @(posedge clk);
        #1;
        cyc++;
        es    = q_s.pop_front();
        ed    = q_d.pop_front();
        ep    = es;
        ep.hs = ~es.hs;
        ep.vs = ~es.vs;
        check_obs("small_mode", grab_s(), es);
        check_obs("inv_polarity", grab_p(), ep);
        check_obs("default_mode", grab_d(), ed);
    endtask

    initial begin
        int         last_ls;
        int         last_fs;
        int         de_n;
        int         vs_n;
        logic       found;
        logic [4:0] prev_x;

        st_s.h = 0; st_s.v = 0; st_s.o = '0;
        st_d.h = 0; st_d.v = 0; st_d.o = '0;

        // Reset held with pix_ce high: reset must win.
        repeat (3) step(1'b1, 1'b1);
        chk("rst_x", 32'(s_if.x), 0);
        chk("rst_de", 32'(d_if.de), 0);
        chk("rst_hsync_idle_high", 32'(d_if.vga_h_sync), 1);
        chk("rst_pos_vsync_idle_low", 32'(p_if.vga_v_sync), 0);

        step(1'b0, 1'b1);
        chk("first_x", 32'(d_if.x), 0);
        chk("first_de", 32'(s_if.de), 1);
        chk("first_frame_start", 32'(d_if.frame_start), 1);

        last_ls = -1;
        last_fs = -1;
        de_n    = 0;
        vs_n    = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 1'b1);
            if (d_if.line_start) begin
                if (last_ls >= 0) chk("d_line_period", 32'(cyc - last_ls), 800);
                last_ls = cyc;
            end
            if (st_d.o.x inside {10'd655, 10'd656, 10'd751, 10'd752}) begin
                chk("d_hsync_window", 32'(d_if.vga_h_sync),
                    (st_d.o.x >= 10'd656 && st_d.o.x <= 10'd751) ? 0 : 1);
            end
            if (s_if.frame_start) begin
                if (last_fs >= 0) begin
                    chk("s_frame_period", 32'(cyc - last_fs), 300);
                    chk("s_de_per_frame", 32'(de_n), 96);
                    chk("s_vsync_clks_per_frame", 32'(vs_n), 50);
                end
                last_fs = cyc;
                de_n    = 0;
                vs_n    = 0;
            end
            de_n += int'(s_if.de);
            vs_n += int'(!s_if.vga_v_sync);
`ifdef VGA_TIMING_FETCH_EN
            fde_hist.push_back(s_if.fetch_de);
            if (fde_hist.size() > LEAD) chk("fetch_de_lead", 32'(s_if.de), 32'(fde_hist.pop_front()));
            if (st_s.o.x == 10'(S_HT - 2)) begin
                chk("s_fetch_line_wrap_x", 32'(s_if.fetch_x), 0);
                chk("s_fetch_line_wrap_y", 32'(s_if.fetch_y), (32'(st_s.o.y) + 1) % S_VT);
            end
            if (st_s.o.x == 10'(S_HT - 1) && st_s.o.y == 10'(S_VT - 1)) begin
                chk("s_fetch_frame_wrap_x", 32'(s_if.fetch_x), 1);
                chk("s_fetch_frame_wrap_y", 32'(s_if.fetch_y), 0);
            end
            if (st_d.o.x == 10'd798) begin
                chk("d_fetch_798_x", 32'(d_if.fetch_x), 0);
                chk("d_fetch_798_y", 32'(d_if.fetch_y), 32'(st_d.o.y) + 1);
            end
`endif
        end

        // Half-rate pixel enable: periods double, x holds while pix_ce is low.
        last_fs = -1;
        for (int i = 0; i < 1200; i++) begin
            prev_x = s_if.x;
            step(1'b0, (i % 2) == 0);
            if ((i % 2) != 0) chk("s_x_hold", 32'(s_if.x), 32'(prev_x));
            if (s_if.frame_start) begin
                if (last_fs >= 0) chk("s_frame_period_half_ce", 32'(cyc - last_fs), 600);
                last_fs = cyc;
            end
        end

        // Mid-frame reset.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b0, 1'b1);
            if (s_if.x == 5'd10 && s_if.y == 4'd4) found = 1'b1;
        end
        chk("s_reach_x10_y4", 32'(found), 1);
        repeat (3) step(1'b1, 1'b1);
        chk("midrst_x", 32'(s_if.x), 0);
        chk("midrst_y", 32'(s_if.y), 0);
        chk("midrst_line_start", 32'(s_if.line_start), 0);
        chk("midrst_hsync", 32'(s_if.vga_h_sync), 1);
        step(1'b0, 1'b1);
        chk("release_x", 32'(s_if.x), 0);
        chk("release_y", 32'(s_if.y), 0);
        chk("release_frame_start", 32'(s_if.frame_start), 1);
        step(1'b0, 1'b0);
        chk("idle_ce_no_strobe", 32'(s_if.line_start), 0);
        step(1'b0, 1'b1);
        chk("advance_after_idle_x", 32'(s_if.x), 1);

        chk("scoreboard_drained", 32'(q_s.size() + q_d.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
